hdlc_rx_deframer: RTL and testbench

//  Serial receive front end of the HDLC controller: samples Rx and hunts for flags (8'h7E).

---
 rtl/hdlc_pkg.sv | 21 ++
 rtl/hdlc_rx_byte_pack.sv | 80 ++++++++
 rtl/hdlc_rx_deframer.sv | 136 +++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
//------------------------------------------------------------------------------
// Module : hdlc_pkg
// Brief  : Shared HDLC receive constants and state type.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package hdlc_pkg;
    localparam logic [7:0] HDLC_FLAG  = 8'h7E;
    localparam logic [2:0] ABORT_ONES = 3'd7;
    localparam logic [2:0] STUFF_ONES = 3'd5;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        OPEN = 2'd1,
        DATA = 2'd2
    } rx_state_t;
endpackage

`default_nettype wire

// File: rtl/hdlc_rx_byte_pack.sv
//------------------------------------------------------------------------------
// Module : hdlc_rx_byte_pack
// Brief  : Packs de-stuffed bits LSB-first into bytes and counts whole bytes.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module hdlc_rx_byte_pack (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       bit_i,
    input  logic       bit_vld_i,
    output logic       byte_done_o,
    output logic [2:0] bitcnt_o,
    output logic [7:0] bytecnt_o,
    output logic [7:0] data_o,
    output logic       new_byte_o
);
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] bytecnt_q, bytecnt_d;
    logic [7:0] data_q, data_d;
    logic       new_byte_q, new_byte_d;
    logic       w_done;

    // Clear and a valid bit never coincide: the window drops all valid bits on clear.
    assign w_done = en_i && bit_vld_i && (bitcnt_q == 3'd7);

    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        bytecnt_d  = bytecnt_q;
        data_d     = data_q;
        new_byte_d = 1'b0;
        if (en_i) begin
            if (clr_i) begin
                bitcnt_d  = 3'd0;
                shift_d   = 7'd0;
                bytecnt_d = 8'd0;
            end else if (bit_vld_i) begin
                shift_d  = {bit_i, shift_q[6:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (w_done) begin
                    data_d     = {bit_i, shift_q};
                    new_byte_d = 1'b1;
                    if (bytecnt_q != 8'hFF) begin
                        bytecnt_d = bytecnt_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bitcnt_q   <= 3'd0;
            shift_q    <= 7'd0;
            bytecnt_q  <= 8'd0;
            data_q     <= 8'h00;
            new_byte_q <= 1'b0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            bytecnt_q  <= bytecnt_d;
            data_q     <= data_d;
            new_byte_q <= new_byte_d;
        end
    end

    assign byte_done_o = w_done;
    assign bitcnt_o    = bitcnt_q;
    assign bytecnt_o   = bytecnt_q;
    assign data_o      = data_q;
    assign new_byte_o  = new_byte_q;
endmodule

`default_nettype wire

// File: rtl/hdlc_rx_deframer.sv
//------------------------------------------------------------------------------
// Module : hdlc_rx_deframer
// Brief  : HDLC receive front end: flag hunt, zero de-stuffing, abort detect.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int unsigned MIN_FRAME_BYTES = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_EoF,
    output logic       Rx_FrameError
);
    rx_state_t  state_q, state_d;
    logic [7:0] win_q, win_d;
    logic [7:0] vm_q, vm_d;
    logic [2:0] ones_q, ones_d;
    logic       valid_q, valid_d;
    logic       flag_q, flag_d, abort_q, abort_d, eof_q, eof_d, ferr_q, ferr_d;

    logic       w_stuff, w_flag, w_abort, w_clr;
    logic [7:0] w_win_sh;
    logic       w_byte_done;
    logic [2:0] w_bitcnt;
    logic [7:0] w_bytecnt;

    // Window, mask and ones counter; kept apart from the FSM so the packer
    // output feeding the FSM forms no loop through a single process.
    always_comb begin
        w_win_sh = {win_q[6:0], Rx};
        w_stuff  = !Rx && (ones_q == STUFF_ONES);
        w_flag   = RxEN && (w_win_sh == HDLC_FLAG);
        w_abort  = RxEN && Rx && (ones_q == ABORT_ONES - 3'd1) && (state_q != HUNT);
        w_clr    = w_flag || w_abort;
        win_d    = win_q;
        vm_d     = vm_q;
        ones_d   = ones_q;
        if (RxEN) begin
            win_d = w_win_sh;
            vm_d  = w_clr ? 8'h00 : {vm_q[6:0], (state_q != HUNT) && !w_stuff};
            if (!Rx) begin
                ones_d = 3'd0;
            end else if (ones_q != ABORT_ONES) begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        flag_d  = 1'b0;
        abort_d = 1'b0;
        eof_d   = 1'b0;
        ferr_d  = 1'b0;
        if (RxEN) begin
            if (w_flag) begin
                flag_d  = 1'b1;
                state_d = OPEN;
                if (state_q == DATA) begin
                    if (w_bitcnt == 3'd0 && {24'd0, w_bytecnt} >= MIN_FRAME_BYTES) begin
                        eof_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (state_q == OPEN && w_bitcnt != 3'd0) begin
                    ferr_d = 1'b1;
                end
            end else if (w_abort) begin
                abort_d = 1'b1;
                state_d = HUNT;
            end else if (w_byte_done && state_q == OPEN) begin
                state_d = DATA;
            end
            valid_d = (state_d != HUNT);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= HUNT;
            win_q   <= 8'h00;
            vm_q    <= 8'h00;
            ones_q  <= 3'd0;
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
            abort_q <= 1'b0;
            eof_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            vm_q    <= vm_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            flag_q  <= flag_d;
            abort_q <= abort_d;
            eof_q   <= eof_d;
            ferr_q  <= ferr_d;
        end
    end

    hdlc_rx_byte_pack u_pack (
        .Clk        (Clk),
        .Rst        (Rst),
        .en_i       (RxEN),
        .clr_i      (w_clr),
        .bit_i      (win_d[7]),
        .bit_vld_i  (vm_d[7]),
        .byte_done_o(w_byte_done),
        .bitcnt_o   (w_bitcnt),
        .bytecnt_o  (w_bytecnt),
        .data_o     (Rx_Data),
        .new_byte_o (Rx_NewByte)
    );

    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_ValidFrame  = valid_q;
    assign Rx_EoF         = eof_q;
    assign Rx_FrameError  = ferr_q;
endmodule

`default_nettype wire

// File: tb/tb_hdlc_rx_deframer.sv
//------------------------------------------------------------------------------
// Module : tb_hdlc_rx_deframer
// Brief  : Self-checking bench: scenario table, hand sequences, random frames.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_hdlc_rx_deframer;
    localparam int MIN_FB = 1;

    logic       Clk = 1'b0;
    logic       Rst, Rx, RxEN;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_EoF, Rx_FrameError;

    always #5 Clk = ~Clk;

    hdlc_rx_deframer #(.MIN_FRAME_BYTES(MIN_FB)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rx            (Rx),
        .RxEN          (RxEN),
        .Rx_Data       (Rx_Data),
        .Rx_NewByte    (Rx_NewByte),
        .Rx_FlagDetect (Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_ValidFrame (Rx_ValidFrame),
        .Rx_EoF        (Rx_EoF),
        .Rx_FrameError (Rx_FrameError)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream tokens: flag, stuffed data byte, raw line bit, end of list.
    localparam logic [1:0] K_FLAG = 2'd0, K_BYTE = 2'd1, K_RAW = 2'd2, K_END = 2'd3;
    typedef struct packed { logic [1:0] kind; logic [7:0] val; } tok_t;
    localparam tok_t TE = '{kind: K_END, val: 8'h00};

    function automatic tok_t tf();
        return '{kind: K_FLAG, val: 8'h7E};
    endfunction
    function automatic tok_t tb(input logic [7:0] v);
        return '{kind: K_BYTE, val: v};
    endfunction
    function automatic tok_t tr(input logic b);
        return '{kind: K_RAW, val: {7'd0, b}};
    endfunction

    typedef struct {
        tok_t [15:0] toks;
        int          mode;
        int          nb;
        logic [7:0]  first_data;
        logic [7:0]  last_data;
        int          flags;
        int          eofs;
        int          ferrs;
        int          aborts;
        logic        valid;
    } vec_t;

    // ---------------- reference model (bit queue with ages) ----------------
    typedef struct { logic b; int age; } pb_t;
    pb_t        pend[$];
    bit         m_open;
    int         m_ones, m_hist, m_nbits, m_bytes, m_acc;
    logic [7:0] e_data;
    logic       e_nb, e_flag, e_abort, e_eof, e_ferr, e_valid;

    task automatic model_reset();
        pend.delete();
        m_open = 0; m_ones = 0; m_hist = 0; m_nbits = 0; m_bytes = 0; m_acc = 0;
        e_data = 8'h00; e_valid = 0;
        e_nb = 0; e_flag = 0; e_abort = 0; e_eof = 0; e_ferr = 0;
    endtask

    task automatic model_step(input logic b);
        bit stuff, reach7;
        e_nb = 0; e_flag = 0; e_abort = 0; e_eof = 0; e_ferr = 0;
        stuff  = (b == 1'b0) && (m_ones == 5);
        reach7 = b && (m_ones == 6);
        m_ones = b ? ((m_ones < 7) ? m_ones + 1 : 7) : 0;
        m_hist = ((m_hist << 1) | int'(b)) & 255;
        foreach (pend[i]) pend[i].age++;
        if (m_open && !stuff) pend.push_back('{b: b, age: 0});
        if (m_hist == 8'h7E) begin
            e_flag = 1;
            pend.delete();
            if (m_open) begin
                if (m_nbits != 0) e_ferr = 1;
                else if (m_bytes >= MIN_FB) e_eof = 1;
                else if (m_bytes > 0) e_ferr = 1;
            end
            m_open = 1; m_nbits = 0; m_bytes = 0; m_acc = 0;
        end else if (reach7 && m_open) begin
            e_abort = 1;
            pend.delete();
            m_open = 0; m_nbits = 0; m_bytes = 0; m_acc = 0;
        end else if (pend.size() > 0 && pend[0].age == 7) begin
            m_acc = m_acc | (int'(pend[0].b) << m_nbits);
            void'(pend.pop_front());
            m_nbits++;
            if (m_nbits == 8) begin
                e_data  = m_acc[7:0];
                e_nb    = 1;
                m_nbits = 0;
                m_acc   = 0;
                if (m_bytes < 255) m_bytes++;
            end
        end
        e_valid = m_open;
    endtask

    // ---------------- stimulus helpers ----------------
    int         en_mode = 0;
    int         tx_run = 0;
    int         cnt_nb, cnt_flag, cnt_eof, cnt_ferr, cnt_abort;
    logic [7:0] first_data, last_data;

    task automatic clear_counts();
        cnt_nb = 0; cnt_flag = 0; cnt_eof = 0; cnt_ferr = 0; cnt_abort = 0;
        first_data = 8'h00; last_data = 8'h00;
    endtask

    task automatic cycle(input logic b, input logic en, input logic rst);
        Rx = b; RxEN = en; Rst = rst;
        if (rst) model_reset();
        else if (en) model_step(b);
        else begin
            e_nb = 0; e_flag = 0; e_abort = 0; e_eof = 0; e_ferr = 0;
        end
        @(posedge Clk);
        #1;
        chk("Rx_Data", Rx_Data, e_data);
        chk("Rx_NewByte", Rx_NewByte, e_nb);
        chk("Rx_FlagDetect", Rx_FlagDetect, e_flag);
        chk("Rx_AbortDetect", Rx_AbortDetect, e_abort);
        chk("Rx_ValidFrame", Rx_ValidFrame, e_valid);
        chk("Rx_EoF", Rx_EoF, e_eof);
        chk("Rx_FrameError", Rx_FrameError, e_ferr);
        if (!en && !rst)
            chk("pulse_after_idle",
                {Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError}, 0);
        if (Rx_NewByte) begin
            if (cnt_nb == 0) first_data = Rx_Data;
            last_data = Rx_Data;
            cnt_nb++;
        end
        if (Rx_FlagDetect)  cnt_flag++;
        if (Rx_EoF)         cnt_eof++;
        if (Rx_FrameError)  cnt_ferr++;
        if (Rx_AbortDetect) cnt_abort++;
    endtask

    task automatic send_bit(input logic b);
        if (en_mode == 1) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end else if (en_mode == 2) begin
            while ($urandom_range(0, 3) == 0) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        cycle(b, 1'b1, 1'b0);
    endtask

    task automatic send_token(input tok_t t);
        logic [7:0] f;
        f = 8'h7E;
        case (t.kind)
            K_FLAG: begin
                for (int i = 0; i < 8; i++) send_bit(f[i]);
                tx_run = 0;
            end
            K_BYTE: begin
                for (int i = 0; i < 8; i++) begin
                    send_bit(t.val[i]);
                    tx_run = t.val[i] ? tx_run + 1 : 0;
                    if (tx_run == 5) begin
                        send_bit(1'b0);
                        tx_run = 0;
                    end
                end
            end
            K_RAW: begin
                send_bit(t.val[0]);
                tx_run = 0;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        tx_run = 0;
        clear_counts();
    endtask

    vec_t vecs[7];

    initial begin
        Rx = 1'b0; RxEN = 1'b0; Rst = 1'b1;
        model_reset();

        // A trailing 0 after AA lets the whole byte drain through the window before the abort.
        vecs[0] = '{toks: {tf(), tf(), tb(8'hA5), tb(8'h3C), tf(), {11{TE}}}, mode: 0,
                    nb: 2, first_data: 8'hA5, last_data: 8'h3C, flags: 3, eofs: 1, ferrs: 0, aborts: 0, valid: 1'b1};
        vecs[1] = '{toks: {tf(), tf(), tb(8'hA5), tb(8'h3C), tf(), {11{TE}}}, mode: 1,
                    nb: 2, first_data: 8'hA5, last_data: 8'h3C, flags: 3, eofs: 1, ferrs: 0, aborts: 0, valid: 1'b1};
        vecs[2] = '{toks: {tf(), tb(8'hFF), tf(), {13{TE}}}, mode: 0,
                    nb: 1, first_data: 8'hFF, last_data: 8'hFF, flags: 2, eofs: 1, ferrs: 0, aborts: 0, valid: 1'b1};
        vecs[3] = '{toks: {tf(), tb(8'hF8), tf(), {13{TE}}}, mode: 0,
                    nb: 1, first_data: 8'hF8, last_data: 8'hF8, flags: 2, eofs: 1, ferrs: 0, aborts: 0, valid: 1'b1};
        vecs[4] = '{toks: {tf(), tr(1'b1), tr(1'b0), tr(1'b1), tf(), {11{TE}}}, mode: 0,
                    nb: 0, first_data: 8'h00, last_data: 8'h00, flags: 2, eofs: 0, ferrs: 1, aborts: 0, valid: 1'b1};
        vecs[5] = '{toks: {tf(), tb(8'hAA), tr(1'b0), {8{tr(1'b1)}}, {5{TE}}}, mode: 0,
                    nb: 1, first_data: 8'hAA, last_data: 8'hAA, flags: 1, eofs: 0, ferrs: 0, aborts: 1, valid: 1'b0};
        vecs[6] = '{toks: {tf(), tb(8'hAA), tr(1'b0), {8{tr(1'b1)}}, tf(), {4{TE}}}, mode: 0,
                    nb: 1, first_data: 8'hAA, last_data: 8'hAA, flags: 2, eofs: 0, ferrs: 0, aborts: 1, valid: 1'b1};

        do_reset();

        for (int v = 0; v < 7; v++) begin
            do_reset();
            en_mode = vecs[v].mode;
            for (int t = 15; t >= 0; t--) begin
                if (vecs[v].toks[t].kind == K_END) break;
                send_token(vecs[v].toks[t]);
            end
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d_newbyte_count", v), cnt_nb, vecs[v].nb);
            chk($sformatf("v%0d_first_data", v), first_data, vecs[v].first_data);
            chk($sformatf("v%0d_last_data", v), last_data, vecs[v].last_data);
            chk($sformatf("v%0d_flag_count", v), cnt_flag, vecs[v].flags);
            chk($sformatf("v%0d_eof_count", v), cnt_eof, vecs[v].eofs);
            chk($sformatf("v%0d_ferr_count", v), cnt_ferr, vecs[v].ferrs);
            chk($sformatf("v%0d_abort_count", v), cnt_abort, vecs[v].aborts);
            chk($sformatf("v%0d_valid", v), Rx_ValidFrame, vecs[v].valid);
        end

        // Reset mid-byte inside a frame, then a run of ones while hunting.
        en_mode = 0;
        do_reset();
        send_token(tf());
        send_token(tb(8'h12));
        send_token(tr(1'b1));
        send_token(tr(1'b0));
        send_token(tr(1'b1));
        cycle(1'b1, 1'b1, 1'b1);
        chk("rst_data", Rx_Data, 8'h00);
        chk("rst_pulses", {Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError}, 0);
        chk("rst_valid", Rx_ValidFrame, 0);
        clear_counts();
        repeat (10) send_token(tr(1'b1));
        chk("hunt_ones_abort", cnt_abort, 0);
        chk("hunt_ones_valid", Rx_ValidFrame, 0);
        send_token(tf());
        send_token(tb(8'h55));
        send_token(tf());
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        chk("after_rst_eof", cnt_eof, 1);
        chk("after_rst_data", last_data, 8'h55);
        chk("after_rst_newbyte", cnt_nb, 1);

        // Random frames, random enable gaps, all outputs compared every cycle.
        en_mode = 2;
        do_reset();
        for (int fr = 0; fr < 80; fr++) begin
            int n;
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 12)) send_token(tr(1'($urandom_range(0, 1))));
            send_token(tf());
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) send_token(tb(8'($urandom_range(0, 255))));
            case ($urandom_range(0, 3))
                0, 1: send_token(tf());
                2: begin
                    repeat ($urandom_range(1, 10)) send_token(tr(1'($urandom_range(0, 1))));
                    send_token(tf());
                end
                default: repeat (8) send_token(tr(1'b1));
            endcase
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
